id_stage_hs: RTL and testbench

Parametrised decode stage with a registered ID/EX output and valid/ready handshakes on both sides. It sits between the IF/ID register and the execute stage. It decodes all RV32I base opcodes and generates the I/S/B/U/J immediates. It also contains the register file, with an optional write-back bypass, detects load-use hazards against the instruction it holds, and supports pipeline flush.

---
 rtl/id_stage_hs.sv | 235 +++++++++++++++++++++++
 tb/tb_id_stage_hs.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage_hs.sv
// RV32I decode stage: register file, opcode/immediate decode, load-use stall
// detection and a registered ID/EX output with valid/ready handshakes.
module id_stage_hs #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_alu_src,
  output logic            out_mem_to_reg,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal,
  output logic [3:0]      out_alu_op
);

  localparam int RA = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Indices at or above NREGS are outside the implemented file.
  function automatic logic reg_in_range(input logic [4:0] idx);
    return (NREGS >= 32) || (int'(idx) < NREGS);
  endfunction

  logic [XLEN-1:0] regs_r [NREGS];

  logic [6:0]      opcode_s;
  logic [2:0]      f3_s;
  logic            f7b5_s;
  logic [4:0]      rs1_s, rs2_s, rd_s;
  logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [XLEN-1:0] rs1_data_s, rs2_data_s, imm_s;
  logic            reg_write_s, alu_src_s, mem_to_reg_s, mem_read_s;
  logic            mem_write_s, branch_s, jump_s, illegal_s;
  logic [3:0]      alu_op_s;
  logic            rs1_used_s, rs2_used_s;
  logic            hz_s, capture_s;

  assign opcode_s = in_instr[6:0];
  assign rd_s     = in_instr[11:7];
  assign f3_s     = in_instr[14:12];
  assign rs1_s    = in_instr[19:15];
  assign rs2_s    = in_instr[24:20];
  assign f7b5_s   = in_instr[30];

  assign imm_i_s = XLEN'($signed(in_instr[31:20]));
  assign imm_s_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b_s = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u_s = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j_s = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  // Register file write port; x0 and out-of-range indices are never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0) && reg_in_range(wb_rd)) begin
      regs_r[wb_rd[RA-1:0]] <= wb_data;
    end
  end

  // Read ports with optional same-cycle write-back bypass.
  always_comb begin
    rs1_data_s = '0;
    rs2_data_s = '0;
    if ((rs1_s == 5'd0) || !reg_in_range(rs1_s)) rs1_data_s = '0;
    else if (WB_BYPASS && wb_we && (wb_rd == rs1_s)) rs1_data_s = wb_data;
    else rs1_data_s = regs_r[rs1_s[RA-1:0]];
    if ((rs2_s == 5'd0) || !reg_in_range(rs2_s)) rs2_data_s = '0;
    else if (WB_BYPASS && wb_we && (wb_rd == rs2_s)) rs2_data_s = wb_data;
    else rs2_data_s = regs_r[rs2_s[RA-1:0]];
  end

  // Opcode decode into control bits, immediate and source-use flags.
  always_comb begin
    reg_write_s  = 1'b0;
    alu_src_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    branch_s     = 1'b0;
    jump_s       = 1'b0;
    illegal_s    = 1'b0;
    alu_op_s     = 4'b0000;
    imm_s        = '0;
    rs1_used_s   = 1'b0;
    rs2_used_s   = 1'b0;
    case (opcode_s)
      OP_R: begin
        reg_write_s = 1'b1;
        alu_op_s    = {f7b5_s, f3_s};
        rs1_used_s  = 1'b1;
        rs2_used_s  = 1'b1;
      end
      OP_IMM: begin
        reg_write_s = 1'b1;
        alu_src_s   = 1'b1;
        alu_op_s    = {(f3_s == 3'b101) ? f7b5_s : 1'b0, f3_s};
        imm_s       = imm_i_s;
        rs1_used_s  = 1'b1;
      end
      OP_LOAD: begin
        reg_write_s  = 1'b1;
        alu_src_s    = 1'b1;
        mem_to_reg_s = 1'b1;
        mem_read_s   = 1'b1;
        imm_s        = imm_i_s;
        rs1_used_s   = 1'b1;
      end
      OP_STORE: begin
        alu_src_s   = 1'b1;
        mem_write_s = 1'b1;
        imm_s       = imm_s_s;
        rs1_used_s  = 1'b1;
        rs2_used_s  = 1'b1;
      end
      OP_BRANCH: begin
        branch_s   = 1'b1;
        alu_op_s   = {1'b1, f3_s};
        imm_s      = imm_b_s;
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b1;
      end
      OP_LUI: begin
        reg_write_s = 1'b1;
        alu_src_s   = 1'b1;
        alu_op_s    = 4'b1111;
        imm_s       = imm_u_s;
      end
      OP_AUIPC: begin
        reg_write_s = 1'b1;
        alu_src_s   = 1'b1;
        imm_s       = imm_u_s;
      end
      OP_JAL: begin
        reg_write_s = 1'b1;
        jump_s      = 1'b1;
        imm_s       = imm_j_s;
      end
      OP_JALR: begin
        reg_write_s = 1'b1;
        jump_s      = 1'b1;
        alu_src_s   = 1'b1;
        imm_s       = imm_i_s;
        rs1_used_s  = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // A held load whose destination feeds the incoming instruction forces one bubble.
  assign hz_s = out_valid && out_mem_read && (out_rd != 5'd0) &&
                ((rs1_used_s && (rs1_s == out_rd)) || (rs2_used_s && (rs2_s == out_rd)));
  assign in_ready  = (!out_valid || out_ready) && !hz_s && !flush;
  assign capture_s = in_valid && in_ready;

  // ID/EX output register: flush beats capture, capture beats drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_rs1_data   <= '0;
      out_rs2_data   <= '0;
      out_imm        <= '0;
      out_rs1        <= 5'd0;
      out_rs2        <= 5'd0;
      out_rd         <= 5'd0;
      out_reg_write  <= 1'b0;
      out_alu_src    <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_branch     <= 1'b0;
      out_jump       <= 1'b0;
      out_illegal    <= 1'b0;
      out_alu_op     <= 4'b0000;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture_s) begin
      out_valid      <= 1'b1;
      out_pc         <= in_pc;
      out_rs1_data   <= rs1_data_s;
      out_rs2_data   <= rs2_data_s;
      out_imm        <= imm_s;
      out_rs1        <= rs1_s;
      out_rs2        <= rs2_s;
      out_rd         <= rd_s;
      out_reg_write  <= reg_write_s;
      out_alu_src    <= alu_src_s;
      out_mem_to_reg <= mem_to_reg_s;
      out_mem_read   <= mem_read_s;
      out_mem_write  <= mem_write_s;
      out_branch     <= branch_s;
      out_jump       <= jump_s;
      out_illegal    <= illegal_s;
      out_alu_op     <= alu_op_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_id_stage_hs.sv
// Directed bench for id_stage_hs: decode, immediates, load-use bubble,
// backpressure, flush and asynchronous reset, with hand-computed expectations.
module tb_id_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        flush, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_reg_write, out_alu_src, out_mem_to_reg, out_mem_read;
  logic        out_mem_write, out_branch, out_jump, out_illegal;
  logic [3:0]  out_alu_op;
  logic [7:0]  ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctrl = {out_reg_write, out_alu_src, out_mem_to_reg, out_mem_read,
                 out_mem_write, out_branch, out_jump, out_illegal};

  id_stage_hs #(.XLEN(32), .NREGS(32), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_alu_src(out_alu_src),
    .out_mem_to_reg(out_mem_to_reg), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch(out_branch), .out_jump(out_jump),
    .out_illegal(out_illegal), .out_alu_op(out_alu_op)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  // ctrl = {reg_write, alu_src, mem_to_reg, mem_read, mem_write, branch, jump, illegal}
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_held_valid", out_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_pc", out_pc, 32'h0);
    chk("reset_imm", out_imm, 32'h0);
    chk("reset_ctrl", ctrl, 8'h00);
    chk("reset_in_ready", in_ready, 1'b1);

    // Preload x2, x1, x5 and attempt a write to x0.
    @(negedge clk); wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h0000_1000;
    @(negedge clk); wb_rd = 5'd1; wb_data = 32'h0000_DEAD;
    @(negedge clk); wb_rd = 5'd5; wb_data = 32'h0000_0077;
    @(negedge clk); wb_rd = 5'd0; wb_data = 32'h0000_1234;
    @(negedge clk); wb_we = 1'b0;
    issue(32'hFFF0_0093, 32'h100);            // ADDI x1,x0,-1
    #1 chk("idle_in_ready", in_ready, 1'b1);

    @(negedge clk);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_imm", out_imm, 32'hFFFF_FFFF);
    chk("addi_ctrl", ctrl, 8'hC0);
    chk("x0_reads_zero", out_rs1_data, 32'h0);
    chk("addi_rd", out_rd, 5'd1);
    chk("addi_pc", out_pc, 32'h100);
    issue(32'h0011_2423, 32'h104);            // SW x1,8(x2)

    @(negedge clk);
    chk("sw_valid", out_valid, 1'b1);
    chk("sw_imm", out_imm, 32'h8);
    chk("sw_ctrl", ctrl, 8'h48);
    chk("sw_rs1_data", out_rs1_data, 32'h1000);
    chk("sw_rs2_data", out_rs2_data, 32'hDEAD);
    chk("sw_pc", out_pc, 32'h104);
    issue(32'hFE00_0EE3, 32'h108);            // BEQ x0,x0,-4

    @(negedge clk);
    chk("beq_imm", out_imm, 32'hFFFF_FFFC);
    chk("beq_ctrl", ctrl, 8'h04);
    chk("beq_alu_op", out_alu_op, 4'b1000);
    issue(32'h0010_00EF, 32'h10C);            // JAL x1,+2048

    @(negedge clk);
    chk("jal_imm", out_imm, 32'h800);
    chk("jal_ctrl", ctrl, 8'h82);
    chk("jal_rd", out_rd, 5'd1);
    issue(32'hABCD_E3B7, 32'h110);            // LUI x7,0xABCDE

    @(negedge clk);
    chk("lui_imm", out_imm, 32'hABCD_E000);
    chk("lui_alu_op", out_alu_op, 4'b1111);
    chk("lui_ctrl", ctrl, 8'hC0);
    issue(32'h4030_D093, 32'h114);            // SRAI x1,x1,3

    @(negedge clk);
    chk("srai_imm", out_imm, 32'h403);
    chk("srai_alu_op", out_alu_op, 4'b1101);
    chk("srai_rs1_data", out_rs1_data, 32'hDEAD);
    issue(32'h0002_2183, 32'h118);            // LW x3,0(x4)

    @(negedge clk);
    chk("lw_ctrl", ctrl, 8'hF0);
    chk("lw_rd", out_rd, 5'd3);
    issue(32'h0061_82B3, 32'h11C);            // ADD x5,x3,x6
    #1 chk("hz_in_ready", in_ready, 1'b0);

    @(negedge clk);
    chk("bubble_valid", out_valid, 1'b0);
    wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'h55;
    #1 chk("after_bubble_in_ready", in_ready, 1'b1);

    @(negedge clk);
    wb_we = 1'b0;
    chk("add_valid", out_valid, 1'b1);
    chk("add_pc", out_pc, 32'h11C);
    chk("add_rd", out_rd, 5'd5);
    chk("add_bypass_rs2", out_rs2_data, 32'h55);
    chk("add_ctrl", ctrl, 8'h80);
    out_ready = 1'b0;
    issue(32'hFFF0_0093, 32'h120);
    #1 chk("bp1_in_ready", in_ready, 1'b0);

    @(negedge clk);
    chk("bp2_valid", out_valid, 1'b1);
    chk("bp2_pc", out_pc, 32'h11C);
    chk("bp2_rs2_data", out_rs2_data, 32'h55);
    chk("bp2_rd", out_rd, 5'd5);
    chk("bp2_ctrl", ctrl, 8'h80);
    chk("bp2_in_ready", in_ready, 1'b0);
    flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 1'b0);

    @(negedge clk);
    chk("flush_kills_valid", out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0;
    #1 chk("bp3_empty_in_ready", in_ready, 1'b1);

    @(negedge clk);
    out_ready = 1'b1;
    chk("no_capture_valid", out_valid, 1'b0);
    issue(32'h0000_007F, 32'h200);            // illegal opcode

    @(negedge clk);
    chk("illegal_ctrl", ctrl, 8'h01);
    chk("illegal_imm", out_imm, 32'h0);
    chk("illegal_alu_op", out_alu_op, 4'b0000);
    issue(32'h0002_8093, 32'h300);            // ADDI x1,x5,0

    @(negedge clk);
    chk("pre_rst_x5", out_rs1_data, 32'h77);
    chk("pre_rst_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_pc", out_pc, 32'h0);
    chk("async_rst_rs1_data", out_rs1_data, 32'h0);

    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_x5", out_rs1_data, 32'h0);
    chk("post_rst_pc", out_pc, 32'h300);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
